// File: rtl/adc_cfg_pkg.sv
// Shared definitions for the per-ADC configuration sequencer: FSM state encoding,
// default ADC count, default chip-select gap and the width of the ADC index.
package adc_cfg_pkg;

  localparam int NUM_ADC_DEF    = 12;
  localparam int GAP_CYCLES_DEF = 4;
  localparam int ADC_IDX_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_PULSE  = 3'd2,
    ST_ARM    = 3'd3,
    ST_WAIT   = 3'd4,
    ST_GAP    = 3'd5,
    ST_FINISH = 3'd6
  } state_t;

endpackage

// File: rtl/adc_lsb_pick.sv
// Combinational priority encoder: index of the lowest set bit of pend, plus a valid flag.
module adc_lsb_pick
  import adc_cfg_pkg::*;
#(
  parameter int N = NUM_ADC_DEF
) (
  input  logic [N-1:0]         pend,
  output logic [ADC_IDX_W-1:0] idx,
  output logic                 vld
);

  // Scan from the top so the last hit (lowest index) wins.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend[i]) begin
        idx = ADC_IDX_W'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_cfg_sequencer.sv
// Walks an ADC enable mask one chip at a time through the serial config engine.
// Optional ADC_SEQ_TIMEOUT_EN adds a per-ADC timeout that flags stuck ADCs in FAIL_MASK.
module adc_cfg_sequencer
  import adc_cfg_pkg::*;
#(
  parameter int NUM_ADC    = NUM_ADC_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int TMO_WIDTH  = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [NUM_ADC-1:0]   EN_MASK,
  input  logic                 CFG_DONE,
  output logic                 CFG_INIT,
  output logic [NUM_ADC-1:0]   CFG_MASK,
  output logic [ADC_IDX_W-1:0] CUR_ADC,
  output logic                 BUSY,
  output logic                 SEQ_DONE,
  output logic [NUM_ADC-1:0]   FAIL_MASK
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  if (NUM_ADC < 1 || NUM_ADC > 16 || GAP_CYCLES < 1 || TMO_WIDTH < 1) begin : g_bad_param
    $error("adc_cfg_sequencer: parameter out of range");
  end

  state_t                 state;
  logic [NUM_ADC-1:0]     pend;
  logic [GAP_W-1:0]       gap_cnt;
  logic [ADC_IDX_W-1:0]   pick_idx;
  logic                   pick_vld;
  logic [NUM_ADC-1:0]     pick_bit;
  logic [NUM_ADC-1:0]     cur_bit;
`ifdef ADC_SEQ_TIMEOUT_EN
  logic [TMO_WIDTH-1:0]   tmo_cnt;
`endif

  adc_lsb_pick #(.N(NUM_ADC)) u_pick (
    .pend (pend),
    .idx  (pick_idx),
    .vld  (pick_vld)
  );

  assign pick_bit = NUM_ADC'(1) << pick_idx;
  assign cur_bit  = NUM_ADC'(1) << CUR_ADC;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      pend      <= '0;
      gap_cnt   <= '0;
      CFG_INIT  <= 1'b0;
      CFG_MASK  <= '0;
      CUR_ADC   <= '0;
      BUSY      <= 1'b0;
      SEQ_DONE  <= 1'b0;
      FAIL_MASK <= '0;
`ifdef ADC_SEQ_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      CFG_INIT <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            pend      <= EN_MASK;
            FAIL_MASK <= '0;
            SEQ_DONE  <= 1'b0;
            BUSY      <= 1'b1;
            state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (ABORT || !pick_vld) begin
            pend  <= '0;
            state <= ST_FINISH;
          end else begin
            CUR_ADC  <= pick_idx;
            CFG_MASK <= pick_bit;
            pend     <= pend & ~pick_bit;
            state    <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          CFG_INIT <= 1'b1;
`ifdef ADC_SEQ_TIMEOUT_EN
          tmo_cnt  <= '0;
`endif
          state    <= ST_ARM;
        end
        // A DONE that is already high must be seen low before it counts as completion.
        ST_ARM, ST_WAIT: begin
`ifdef ADC_SEQ_TIMEOUT_EN
          if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + TMO_WIDTH'(1);
`endif
          if (ABORT) begin
            FAIL_MASK <= FAIL_MASK | cur_bit;
            pend      <= '0;
            gap_cnt   <= '0;
            state     <= ST_GAP;
          end
`ifdef ADC_SEQ_TIMEOUT_EN
          else if (tmo_cnt == '1) begin
            FAIL_MASK <= FAIL_MASK | cur_bit;
            gap_cnt   <= '0;
            state     <= ST_GAP;
          end
`endif
          else if (state == ST_ARM) begin
            if (!CFG_DONE) state <= ST_WAIT;
          end else if (CFG_DONE) begin
            gap_cnt <= '0;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          CFG_MASK <= '0;
          if (ABORT) pend <= '0;
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            state <= ST_SCAN;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        ST_FINISH: begin
          BUSY     <= 1'b0;
          SEQ_DONE <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_cfg_sequencer.sv
// Directed bench for adc_cfg_sequencer with a behavioural config-engine model.
// Timeout cases are exercised when ADC_SEQ_TIMEOUT_EN is defined.
module tb_adc_cfg_sequencer;

`ifdef ADC_SEQ_TIMEOUT_EN
  localparam int TMO_W = 6;
`else
  localparam int TMO_W = 16;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] en_mask = '0;
  logic        done;
  logic        cfg_init;
  logic [11:0] cfg_mask;
  logic [3:0]  cur_adc;
  logic        busy;
  logic        seq_done;
  logic [11:0] fail_mask;

  adc_cfg_sequencer #(.NUM_ADC(12), .GAP_CYCLES(4), .TMO_WIDTH(TMO_W)) dut (
    .CLK       (clk),
    .RST       (rst),
    .START     (start),
    .ABORT     (abort),
    .EN_MASK   (en_mask),
    .CFG_DONE  (done),
    .CFG_INIT  (cfg_init),
    .CFG_MASK  (cfg_mask),
    .CUR_ADC   (cur_adc),
    .BUSY      (busy),
    .SEQ_DONE  (seq_done),
    .FAIL_MASK (fail_mask)
  );

  always #5 clk = ~clk;

  // Engine model: DONE drops 2 cycles after INIT, rises 50 cycles later.
  logic        hold_high = 1'b0;
  logic [11:0] stuck_mask = '0;
  int          eng_cnt;
  logic        eng_stuck;

  always @(posedge clk) begin
    if (rst) begin
      done      <= 1'b1;
      eng_cnt   <= 0;
      eng_stuck <= 1'b0;
    end else if (hold_high) begin
      done <= 1'b1;
    end else if (cfg_init) begin
      eng_cnt   <= 1;
      eng_stuck <= |(cfg_mask & stuck_mask);
    end else if (eng_cnt != 0) begin
      if (eng_cnt == 2) done <= 1'b0;
      if (eng_cnt >= 52) begin
        if (!eng_stuck) done <= 1'b1;
        eng_cnt <= 0;
      end else begin
        eng_cnt <= eng_cnt + 1;
      end
    end
  end

  int          init_cnt;
  int          busy_cycles;
  int          zero_run;
  logic        seen_sel;
  logic [11:0] mask_or;
  logic [3:0]  init_adc[$];
  logic [11:0] init_mask[$];
  int          gaps[$];

  always @(negedge clk) begin
    if (cfg_init) begin
      init_cnt++;
      init_adc.push_back(cur_adc);
      init_mask.push_back(cfg_mask);
    end
    mask_or |= cfg_mask;
    if (busy) busy_cycles++;
    if (cfg_mask != 12'h000) begin
      if (seen_sel && zero_run > 0) gaps.push_back(zero_run);
      zero_run = 0;
      seen_sel = 1'b1;
    end else if (busy && seen_sel) begin
      zero_run++;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    init_cnt    = 0;
    busy_cycles = 0;
    zero_run    = 0;
    seen_sel    = 1'b0;
    mask_or     = '0;
    init_adc.delete();
    init_mask.delete();
    gaps.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    hold_high = 1'b0; stuck_mask = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_mon();
  endtask

  task automatic start_seq(input logic [11:0] m);
    @(posedge clk); #1;
    en_mask = m;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (!seq_done && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 32'(seq_done), 32'd1);
  endtask

  task automatic wait_adc(input string tag, input logic [3:0] idx, input int max);
    int n = 0;
    while (!(cur_adc == idx && cfg_mask != 12'h000) && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 32'(cur_adc), 32'(idx));
  endtask

  initial begin
    clear_mon();
    do_reset();
    chk("rst_init", 32'(cfg_init), 32'd0);
    chk("rst_mask", 32'(cfg_mask), 32'd0);
    chk("rst_cur",  32'(cur_adc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(seq_done), 32'd0);
    chk("rst_fail", 32'(fail_mask), 32'd0);

    // Two ADCs, EN_MASK changed after START must not matter.
    start_seq(12'h005);
    en_mask = 12'hFFF;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_init_early", 32'(cfg_init), 32'd0);
    step(1);
    chk("t1_mask0", 32'(cfg_mask), 32'h001);
    chk("t1_init_mid", 32'(cfg_init), 32'd0);
    step(1);
    chk("t1_init_lat", 32'(cfg_init), 32'd1);
    wait_done("t1_done", 400);
    chk("t1_ninit", 32'(init_cnt), 32'd2);
    chk("t1_ngap", 32'(gaps.size()), 32'd1);
    if (init_cnt == 2) begin
      chk("t1_adc0", 32'(init_adc[0]), 32'd0);
      chk("t1_adc1", 32'(init_adc[1]), 32'd2);
      chk("t1_m0", 32'(init_mask[0]), 32'h001);
      chk("t1_m1", 32'(init_mask[1]), 32'h004);
    end
    if (gaps.size() == 1) chk("t1_gap", 32'(gaps[0]), 32'd4);
    chk("t1_fail", 32'(fail_mask), 32'h000);
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_mask_end", 32'(cfg_mask), 32'h000);

    // Zero-enable: BUSY for two cycles, no INIT.
    clear_mon();
    start_seq(12'h000);
    chk("t2_busy1", 32'(busy), 32'd1);
    chk("t2_done_clr", 32'(seq_done), 32'd0);
    step(1);
    chk("t2_busy2", 32'(busy), 32'd1);
    step(1);
    chk("t2_busy3", 32'(busy), 32'd0);
    chk("t2_done", 32'(seq_done), 32'd1);
    chk("t2_bcyc", 32'(busy_cycles), 32'd2);
    chk("t2_ninit", 32'(init_cnt), 32'd0);

    // START with ABORT in IDLE: START wins.
    clear_mon();
    @(posedge clk); #1;
    en_mask = 12'h001; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("t2b_busy", 32'(busy), 32'd1);
    wait_done("t2b_done", 200);
    chk("t2b_ninit", 32'(init_cnt), 32'd1);
    chk("t2b_fail", 32'(fail_mask), 32'h000);

`ifdef ADC_SEQ_TIMEOUT_EN
    // ADC1 never completes; the timeout flags it.
    do_reset();
    stuck_mask = 12'h002;
    start_seq(12'h003);
    wait_done("t3_done", 600);
    chk("t3_fail", 32'(fail_mask), 32'h002);
    chk("t3_ninit", 32'(init_cnt), 32'd2);
    chk("t3_mask", 32'(cfg_mask), 32'h000);
`endif

    // Abort while waiting on ADC 5.
    do_reset();
    start_seq(12'hFFF);
    wait_adc("t4_reach5", 4'd5, 2000);
    step(10);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    wait_done("t4_done", 200);
    chk("t4_fail", 32'(fail_mask), 32'h020);
    chk("t4_seen", 32'(mask_or), 32'h03F);
    chk("t4_ninit", 32'(init_cnt), 32'd6);
    chk("t4_mask", 32'(cfg_mask), 32'h000);

    // START while BUSY ignored, then RST mid-WAIT, then restart.
    do_reset();
    start_seq(12'h00C);
    wait_adc("t5_reach2", 4'd2, 400);
    step(10);
    start_seq(12'h001);
    step(3);
    chk("t5_cur", 32'(cur_adc), 32'd2);
    chk("t5_mask", 32'(cfg_mask), 32'h004);
    chk("t5_busy", 32'(busy), 32'd1);
    do_reset();
    chk("t5_rmask", 32'(cfg_mask), 32'h000);
    chk("t5_rbusy", 32'(busy), 32'd0);
    chk("t5_rcur", 32'(cur_adc), 32'd0);
    chk("t5_rinit", 32'(cfg_init), 32'd0);
    chk("t5_rdone", 32'(seq_done), 32'd0);
    step(5);
    chk("t5_quiet", 32'(busy), 32'd0);
    start_seq(12'h00A);
    step(1);
    chk("t5_first", 32'(cfg_mask), 32'h002);
    wait_done("t5_done", 400);
    chk("t5_ninit", 32'(init_cnt), 32'd2);
    if (init_cnt == 2) chk("t5_adc1", 32'(init_adc[1]), 32'd3);
    chk("t5_fail", 32'(fail_mask), 32'h000);

    // DONE held high: no false completion.
    do_reset();
    hold_high = 1'b1;
    start_seq(12'h010);
`ifdef ADC_SEQ_TIMEOUT_EN
    wait_done("t6_done", 300);
    chk("t6_fail", 32'(fail_mask), 32'h010);
`else
    step(200);
    chk("t6_busy", 32'(busy), 32'd1);
    chk("t6_nodone", 32'(seq_done), 32'd0);
    chk("t6_mask", 32'(cfg_mask), 32'h010);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    wait_done("t6_done", 50);
    chk("t6_fail", 32'(fail_mask), 32'h010);
`endif
    chk("t6_ninit", 32'(init_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
